lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store requester driving a word-organised 1R1W data memory from the core MEM stage.
//  Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into word accesses.
//  Sub-word stores use read-modify-write. Load data is lane-extracted and sign/zero-extended.
//  Flags misaligned or illegal accesses without touching memory.
// PARAMETERS
//  DEPTH   4   memory depth in 32-bit words; byte address width MAW = $clog2(DEPTH)+2
//  WIDTH   32  data width; fixed at 32 (RV32)
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      reset: synchronous, active-low
//  req_valid     in   1      core request valid
//  req_ready     out  1      request accepted when req_valid && req_ready
//  req_we        in   1      1 = store, 0 = load
//  req_funct3    in   3      RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr      in   32     byte address
//  req_wdata     in   32     store data, LSB-aligned
//  resp_valid    out  1      one-cycle completion pulse; no backpressure
//  resp_rdata    out  32     load result; 0 for stores and errors
//  resp_err      out  1      misaligned, illegal funct3 or out-of-bounds access; valid with resp_valid
//  mem_rd_addr   out  MAW    byte address to memory read port
//  mem_wr_addr   out  MAW    byte address to memory write port; always equals mem_rd_addr
//  mem_wr_din    out  32     write data
//  mem_we        out  1      write enable
//  mem_rd_dout   in   32     memory read data; combinational, same cycle as address
// BEHAVIOUR
//  - FSM states: IDLE, ACCESS, WRITE, RESP.
//  - req_ready = (state==IDLE). In IDLE, a handshake latches we/funct3/addr/wdata.
//  - Next state after the handshake is ACCESS, or RESP with err=1 if the request is illegal.
//  - ACCESS: mem_rd_addr = {addr_q[MAW-1:2],2'b00}.
//  - ACCESS, load: extract and extend the lane, register it into resp_rdata -> RESP.
//  - ACCESS, SW: mem_we=1, mem_wr_din=wdata_q -> RESP.
//  - ACCESS, SB/SH: register merged word = mem_rd_dout with lane replaced -> WRITE.
//    SB lane = addr_q[1:0]; SH lane = addr_q[1].
//  - WRITE: mem_we=1, mem_wr_din = merged word -> RESP.
//  - RESP: resp_valid=1 for exactly one cycle -> IDLE. Next accept is the following cycle.
//  - Latency (handshake cycle = N):
//    load/SW resp_valid at N+2; SB/SH at N+3; error at N+1.
//  - Illegal = funct3 in {011,110,111}, SB/LBU with funct3 1xx on a store,
//    H access with addr[0]=1, or W access with addr[1:0]!=0.
//  - Illegal requests issue no mem_we and perform no read dependence.
//  - Sign extension: LB/LH replicate bit 7/15; LBU/LHU zero-fill.
//  - mem_we is asserted only in ACCESS(SW) or WRITE, and is always gated by rst.
//  - Reset values: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, req_ready=1.
//    Latched request registers reset to 0. Addresses/data reset to 0.
//  - Reset asserted mid-operation (ACCESS/WRITE): no write issued that cycle.
//    Pending request is dropped with no response; next cycle is IDLE.
//  - req_valid while not ready: ignored. Core must hold the request until it is accepted.
// CONFIGURATION
//  LSU_BOUNDS_CHECK_EN defined:
//    addr >= DEPTH*4 (any of req_addr[31:MAW] nonzero) -> resp_err=1 at N+1, no access.
//  LSU_BOUNDS_CHECK_EN undefined:
//    upper address bits are discarded and accesses wrap modulo DEPTH*4 bytes.
// TESTING
//  1. Mem word0=0x8899AABB; LB addr 0x3 -> resp at N+2, rdata=0xFFFFFF88, err=0.
//     LBU addr 0x3 -> 0x00000088.
//  2. SB addr 0x1 data 0x000000CC on word0=0x8899AABB -> mem_we only at N+2.
//     Word0 becomes 0x8899CCBB; resp at N+3.
//  3. SH addr 0x6 data 0x1234 on word1=0 -> word1=0x12340000.
//     Then LH addr 0x6 -> 0x00001234; LHU matches.
//  4. SW addr 0x2 -> resp_err=1 at N+1, mem_we never high, memory unchanged.
//     LH addr 0x1 -> err at N+1.
//  5. Address 0x10 with DEPTH=4: with LSU_BOUNDS_CHECK_EN, err=1 at N+1.
//     Without it, SW 0x10 overwrites word0.
//  6. rst low during the WRITE cycle of an SB -> mem_we=0 that cycle.
//     Memory unchanged, no resp_valid, req_ready=1 after rst releases.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store requester for a word-organised 1R1W memory; sub-word stores use read-modify-write.
// Optional LSU_BOUNDS_CHECK_EN rejects addresses beyond DEPTH*4 bytes instead of wrapping.
module lsu_mem_ctrl #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 32,
   localparam int MAW   = $clog2(DEPTH) + 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [2:0]       req_funct3,
   input  logic [31:0]      req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             resp_valid,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             resp_err,
   output logic [MAW-1:0]   mem_rd_addr,
   output logic [MAW-1:0]   mem_wr_addr,
   output logic [WIDTH-1:0] mem_wr_din,
   output logic             mem_we,
   input  logic [WIDTH-1:0] mem_rd_dout
);

   typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

   state_t           state;
   logic             we_q;
   logic [2:0]       f3_q;
   logic [MAW-1:0]   addr_q;
   logic [WIDTH-1:0] wdata_q;
   logic [WIDTH-1:0] merged_q;

   logic             illegal;
   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;
   logic [WIDTH-1:0] ld_val;
   logic [WIDTH-1:0] st_merge;

   always_comb begin
      illegal = 1'b0;
      case (req_funct3)
         3'b000:         illegal = 1'b0;
         3'b001:         illegal = req_addr[0];
         3'b010:         illegal = |req_addr[1:0];
         3'b100, 3'b101: illegal = req_we | (req_funct3[0] & req_addr[0]);
         default:        illegal = 1'b1;
      endcase
`ifdef LSU_BOUNDS_CHECK_EN
      if (|req_addr[31:MAW]) illegal = 1'b1;
`endif
   end

`ifndef LSU_BOUNDS_CHECK_EN
   // Upper address bits are intentionally dropped: accesses wrap modulo the memory size.
   logic unused_addr_hi;
   assign unused_addr_hi = ^req_addr[31:MAW];
`endif

   // funct3[2] selects zero-extension; funct3[1:0] gives the access size.
   always_comb begin
      ld_byte = mem_rd_dout[{addr_q[1:0], 3'b000} +: 8];
      ld_half = addr_q[1] ? mem_rd_dout[31:16] : mem_rd_dout[15:0];
      case (f3_q[1:0])
         2'b00:   ld_val = {{24{~f3_q[2] & ld_byte[7]}}, ld_byte};
         2'b01:   ld_val = {{16{~f3_q[2] & ld_half[15]}}, ld_half};
         default: ld_val = mem_rd_dout;
      endcase
   end

   always_comb begin
      st_merge = mem_rd_dout;
      if (f3_q[0]) st_merge[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      else         st_merge[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         we_q       <= 1'b0;
         f3_q       <= 3'b000;
         addr_q     <= '0;
         wdata_q    <= '0;
         merged_q   <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               we_q       <= req_we;
               f3_q       <= req_funct3;
               addr_q     <= req_addr[MAW-1:0];
               wdata_q    <= req_wdata;
               resp_rdata <= '0;
               resp_err   <= illegal;
               state      <= illegal ? RESP : ACCESS;
            end
            ACCESS: begin
               if (!we_q) begin
                  resp_rdata <= ld_val;
                  state      <= RESP;
               end else if (f3_q[1]) begin
                  state <= RESP;
               end else begin
                  merged_q <= st_merge;
                  state    <= WRITE;
               end
            end
            WRITE: state <= RESP;
            RESP: begin
               resp_rdata <= '0;
               resp_err   <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign req_ready   = (state == IDLE);
   assign resp_valid  = (state == RESP);
   assign mem_rd_addr = {addr_q[MAW-1:2], 2'b00};
   assign mem_wr_addr = mem_rd_addr;
   assign mem_wr_din  = (state == WRITE) ? merged_q : wdata_q;
   // rst gating keeps a reset landing in ACCESS/WRITE from committing a write.
   assign mem_we      = rst & (((state == ACCESS) & we_q & f3_q[1]) | (state == WRITE));

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: byte-addressed reference model, directed cases then random traffic.
module tb_lsu_mem_ctrl;
   localparam int DEPTH = 4;
   localparam int MAW   = $clog2(DEPTH) + 2;
   localparam int NB    = DEPTH * 4;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           req_valid = 1'b0;
   logic           req_ready;
   logic           req_we = 1'b0;
   logic [2:0]     req_funct3 = 3'b000;
   logic [31:0]    req_addr = '0;
   logic [31:0]    req_wdata = '0;
   logic           resp_valid;
   logic [31:0]    resp_rdata;
   logic           resp_err;
   logic [MAW-1:0] mem_rd_addr;
   logic [MAW-1:0] mem_wr_addr;
   logic [31:0]    mem_wr_din;
   logic           mem_we;
   logic [31:0]    mem_rd_dout;

   logic [31:0] mem [DEPTH];
   logic [7:0]  mb  [NB];
   int          errs = 0;
   int          checks = 0;
   logic [31:0] last_rd;
   logic        last_err;

   lsu_mem_ctrl #(.DEPTH(DEPTH), .WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr), .mem_wr_din(mem_wr_din),
      .mem_we(mem_we), .mem_rd_dout(mem_rd_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_we) mem[mem_wr_addr[MAW-1:2]] <= mem_wr_din;
   assign mem_rd_dout = mem[mem_rd_addr[MAW-1:2]];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: byte-addressed memory, size/alignment rules, expected latency and write cycle.
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output logic err, output logic [31:0] rd,
                        output int lat, output int wecyc);
      int size, ea;
      logic [31:0] v;
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      err  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]) ||
             (size == 2 && a % 2 != 0) || (size == 4 && a % 4 != 0);
`ifdef LSU_BOUNDS_CHECK_EN
      if (a >= NB) err = 1'b1;
`endif
      ea = int'(a % NB);
      rd = '0; lat = 1; wecyc = 0;
      if (!err && we) begin
         for (int i = 0; i < size; i++) mb[ea+i] = d[8*i +: 8];
         lat   = (size == 4) ? 2 : 3;
         wecyc = lat - 1;
      end else if (!err) begin
         v = '0;
         for (int i = 0; i < size; i++) v = v | (32'(mb[ea+i]) << (8*i));
         if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
         rd  = v;
         lat = 2;
      end
   endtask

   task automatic chk_mem(input string tag);
      for (int w = 0; w < DEPTH; w++)
         chk(tag, mem[w], {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]});
   endtask

   task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      logic        e_err;
      logic [31:0] e_rd;
      int          e_lat, e_wc, lat, we_cnt, we_cyc;
      bit          got;
      model(we, f3, a, d, e_err, e_rd, e_lat, e_wc);
      @(negedge clk);
      chk("ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0; we_cnt = 0; we_cyc = 0; got = 1'b0;
      while (!got && lat < 8) begin
         @(negedge clk);
         lat++;
         if (mem_we) begin
            we_cnt++;
            we_cyc = lat;
            chk("wr_addr", 32'(mem_wr_addr), 32'(mem_rd_addr));
         end
         if (resp_valid) begin
            got      = 1'b1;
            last_rd  = resp_rdata;
            last_err = resp_err;
         end
      end
      chk("latency", lat, e_lat);
      if (got) begin
         chk("err", 32'(last_err), 32'(e_err));
         chk("rdata", last_rd, e_rd);
      end
      chk("we_cnt", we_cnt, (e_wc != 0) ? 1 : 0);
      chk("we_cyc", we_cyc, e_wc);
      @(negedge clk);
      chk("resp_1cyc", 32'(resp_valid), 32'd0);
      chk_mem("mem");
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int rv_cnt;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_rvalid", 32'(resp_valid), 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_err", 32'(resp_err), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_addr", 32'(mem_rd_addr), 32'd0);
      rst = 1'b1;

      xact(1'b1, 3'b010, 32'h0, 32'h8899AABB);
      xact(1'b1, 3'b010, 32'h4, 32'h0);
      xact(1'b1, 3'b010, 32'h8, $urandom);
      xact(1'b1, 3'b010, 32'hC, $urandom);

      xact(1'b0, 3'b000, 32'h3, 32'h0);
      chk("lb3", last_rd, 32'hFFFFFF88);
      xact(1'b0, 3'b100, 32'h3, 32'h0);
      chk("lbu3", last_rd, 32'h00000088);
      xact(1'b1, 3'b000, 32'h1, 32'h000000CC);
      chk("sb_word0", mem[0], 32'h8899CCBB);
      xact(1'b1, 3'b001, 32'h6, 32'h00001234);
      chk("sh_word1", mem[1], 32'h12340000);
      xact(1'b0, 3'b001, 32'h6, 32'h0);
      chk("lh6", last_rd, 32'h00001234);
      xact(1'b0, 3'b101, 32'h6, 32'h0);
      chk("lhu6", last_rd, 32'h00001234);
      xact(1'b1, 3'b010, 32'h2, 32'hFFFFFFFF);
      chk("sw2_err", 32'(last_err), 32'd1);
      xact(1'b0, 3'b001, 32'h1, 32'h0);
      chk("lh1_err", 32'(last_err), 32'd1);
      xact(1'b1, 3'b100, 32'h0, 32'h0);
      xact(1'b0, 3'b111, 32'h0, 32'h0);
      xact(1'b0, 3'b000, 32'h2, 32'h0);
      xact(1'b0, 3'b001, 32'h2, 32'h0);
      xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
      xact(1'b0, 3'b010, 32'h0, 32'h0);

      // Reset landing in the WRITE cycle of an SB.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h2; req_wdata = 32'h55;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_we", 32'(mem_we), 32'd0);
      chk("midrst_rv", 32'(resp_valid), 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("midrst_ready", 32'(req_ready), 32'd1);
      rv_cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (resp_valid) rv_cnt++;
      end
      chk("midrst_noresp", rv_cnt, 0);
      chk_mem("midrst_mem");

      for (int n = 0; n < 80; n++) begin
         logic [31:0] a;
         a = $urandom_range(NB * 2 - 1);
         if ($urandom_range(7) == 0) a = a | 32'h0000_0100;
         xact(1'($urandom_range(1)), 3'($urandom_range(7)), a, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
